// File: rtl/uart_debug_ctrl.sv
// ============================================================================
// uart_debug_ctrl
// ----------------------------------------------------------------------------
// Command/response engine sitting between uart_rx and the tx char FIFO of the
// UART debug top. It decodes single-byte commands from the receiver, emits
// single-step pulses to the pipeline clock gate, reads 32-bit probe words
// through an external selector mux and pushes formatted response bytes into
// the char FIFO while honouring its full flag.
//
// Commands (accepted only while idle):
//   'S' (0x53)        : pulse pipe_step for STEP_LEN cycles, reply "K\r\n"
//   'R' (0x52) + sel  : select probe word sel[SEL_W-1:0], reply with the word
//   anything else     : reply "?\r\n"
// Bytes that arrive while a command is executing are dropped and counted in
// drop_cnt, which saturates at 255.
//
// Build option:
//   UART_DUMP_HEX_EN  defined   -> word reply is 8 uppercase ASCII hex digits
//                                  (MS nibble first) followed by CR LF
//                     undefined -> word reply is 4 raw bytes, MS byte first,
//                                  no CR LF
//
// Parameters:
//   SEL_W     probe selector width (up to 64 probe words at the default 6)
//   STEP_LEN  pipe_step pulse width in clk cycles (1..255)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx_data      received byte, valid while rx_data_rdy is high
//   rx_data_rdy  receiver ready; each rising edge delivers one byte
//   probe_sel    selector to the external probe mux
//   probe_data   probe mux output, combinational from probe_sel
//   pipe_step    step pulse to the pipeline clock gate
//   fifo_din     byte to the char FIFO
//   fifo_wr_en   one-cycle FIFO push strobe, never asserted while fifo_full
//   fifo_full    char FIFO full
//   busy         high whenever a command is in progress
//   drop_cnt     bytes dropped while busy, saturating at 255
// ============================================================================
module uart_debug_ctrl #(
    parameter int SEL_W    = 6,
    parameter int STEP_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_rdy,
    output logic [SEL_W-1:0] probe_sel,
    input  logic [31:0]      probe_data,
    output logic             pipe_step,
    output logic [7:0]       fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GET_SEL = 3'd1;
    localparam logic [2:0] STEP    = 3'd2;
    localparam logic [2:0] LATCH   = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;

    // Which response the SEND state is emitting.
    localparam logic [1:0] RESP_QM   = 2'd0;  // "?\r\n"
    localparam logic [1:0] RESP_OK   = 2'd1;  // "K\r\n"
    localparam logic [1:0] RESP_WORD = 2'd2;  // probe word

    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_READ = 8'h52;  // 'R'
    localparam logic [7:0] CH_QM    = 8'h3F;  // '?'
    localparam logic [7:0] CH_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // Index of the final byte of each response.
    localparam logic [3:0] CHAR_LAST = 4'd2;
`ifdef UART_DUMP_HEX_EN
    localparam logic [3:0] WORD_LAST = 4'd9;
`else
    localparam logic [3:0] WORD_LAST = 4'd3;
`endif

    // The pulse counter counts down from STEP_LEN-1 so that the pulse lasts
    // exactly STEP_LEN cycles including the cycle the STEP state is entered.
    localparam logic [7:0] STEP_LAST = 8'(STEP_LEN - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]       state;
    logic             rdy_q;       // rx_data_rdy history for edge detection
    logic [7:0]       step_cnt;    // remaining pipe_step cycles minus one
    logic [1:0]       resp_kind;
    logic [3:0]       byte_idx;    // index of the next response byte to push
    logic [31:0]      shadow;      // probe word captured on leaving LATCH
    logic [SEL_W-1:0] sel_q;
    logic             step_q;
    logic [7:0]       drop_q;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic       byte_event;
    logic       push;
    logic [3:0] last_idx;
    logic [7:0] resp_byte;

    // One event per rising edge of rx_data_rdy; a held-high rdy is ignored.
    assign byte_event = rx_data_rdy & ~rdy_q;

    // fifo_full is used combinationally so a byte is never offered while full
    // and the index simply holds until space appears.
    assign push = (state == SEND) && !fifo_full;

    assign last_idx = (resp_kind == RESP_WORD) ? WORD_LAST : CHAR_LAST;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};   // 0x37 + 10 = 'A'
    endfunction

`ifdef UART_DUMP_HEX_EN
    logic [2:0] nib_sel;
    assign nib_sel = 3'd7 - byte_idx[2:0];
`else
    logic [1:0] byte_sel;
    assign byte_sel = 2'd3 - byte_idx[1:0];
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would otherwise infer a latch.
        resp_byte = 8'h00;
        case (resp_kind)
            RESP_QM, RESP_OK: begin
                case (byte_idx)
                    4'd0:    resp_byte = (resp_kind == RESP_OK) ? CH_OK : CH_QM;
                    4'd1:    resp_byte = CH_CR;
                    default: resp_byte = CH_LF;
                endcase
            end
            default: begin
`ifdef UART_DUMP_HEX_EN
                if (byte_idx == 4'd8) begin
                    resp_byte = CH_CR;
                end else if (byte_idx == 4'd9) begin
                    resp_byte = CH_LF;
                end else begin
                    resp_byte = hex_char(shadow[{nib_sel, 2'b00} +: 4]);
                end
`else
                resp_byte = shadow[{byte_sel, 3'b000} +: 8];
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            step_cnt  <= 8'h00;
            resp_kind <= RESP_QM;
            byte_idx  <= 4'd0;
            // NOTE: the shadow word is reset with everything else; it is a
            // single register, not a memory array, so the reset costs nothing
            // and keeps the first word response deterministic in simulation.
            shadow    <= 32'h0;
            sel_q     <= '0;
            step_q    <= 1'b0;
            drop_q    <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision
            // below sees the register values from before this edge.
            rdy_q <= rx_data_rdy;

            // A byte arriving in any state other than IDLE/GET_SEL is lost;
            // this includes the cycle in which SEND finishes.
            if (byte_event && (state != IDLE) && (state != GET_SEL)
                && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'h01;
            end

            case (state)
                IDLE: begin
                    if (byte_event) begin
                        case (rx_data)
                            CMD_STEP: begin
                                state    <= STEP;
                                step_q   <= 1'b1;
                                step_cnt <= STEP_LAST;
                            end
                            CMD_READ: begin
                                state <= GET_SEL;
                            end
                            default: begin
                                state     <= SEND;
                                resp_kind <= RESP_QM;
                                byte_idx  <= 4'd0;
                            end
                        endcase
                    end
                end

                GET_SEL: begin
                    if (byte_event) begin
                        sel_q <= SEL_W'(rx_data);
                        state <= LATCH;
                    end
                end

                LATCH: begin
                    // The mux has had a full cycle to settle on the new sel.
                    shadow    <= probe_data;
                    resp_kind <= RESP_WORD;
                    byte_idx  <= 4'd0;
                    state     <= SEND;
                end

                STEP: begin
                    if (step_cnt == 8'h00) begin
                        step_q    <= 1'b0;
                        resp_kind <= RESP_OK;
                        byte_idx  <= 4'd0;
                        state     <= SEND;
                    end else begin
                        step_cnt <= step_cnt - 8'h01;
                    end
                end

                SEND: begin
                    if (push) begin
                        if (byte_idx == last_idx) begin
                            byte_idx <= 4'd0;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign probe_sel  = sel_q;
    assign pipe_step  = step_q;
    assign fifo_wr_en = push;
    assign fifo_din   = (state == SEND) ? resp_byte : 8'h00;
    assign busy       = (state != IDLE);
    assign drop_cnt   = drop_q;

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (rst) fifo_full |-> !fifo_wr_en);

    a_step_only_in_step : assert property (
        @(posedge clk) disable iff (rst) pipe_step |-> (state == STEP));

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// ============================================================================
// tb_uart_debug_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for uart_debug_ctrl (SEL_W=6, STEP_LEN=3). Directed
// scenarios cover reset, step pulse timing, word read with FIFO back-pressure,
// held rdy, drops and drop counter saturation; a randomized phase then issues
// random commands under random back-pressure. Expected responses come from a
// byte-queue model built from the command rules.
// ============================================================================
`timescale 1ns/1ps
module tb_uart_debug_ctrl;

    localparam int SEL_W    = 6;
    localparam int STEP_LEN = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_data_rdy;
    logic [SEL_W-1:0] probe_sel;
    logic [31:0]      probe_data;
    logic             pipe_step;
    logic [7:0]       fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full;
    logic             busy;
    logic [7:0]       drop_cnt;

    uart_debug_ctrl #(.SEL_W(SEL_W), .STEP_LEN(STEP_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .probe_sel   (probe_sel),
        .probe_data  (probe_data),
        .pipe_step   (pipe_step),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_full   (fifo_full),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Probe mux model: 64 random words, combinational from probe_sel.
    logic [31:0] probe_mem [64];
    assign probe_data = probe_mem[probe_sel];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q [$];   // bytes pushed into the FIFO
    logic [7:0] exp_q [$];   // bytes the model expects
    int         exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO side and step monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wr_en) begin
                check("wr_not_full", 32'(fifo_full), 32'd0);
                got_q.push_back(fifo_din);
            end
            if (pipe_step) check("step_while_busy", 32'(busy), 32'd1);
        end
    end

    // ---------------- reference model ----------------
    task automatic expect_char(input logic [7:0] c);
        exp_q.delete();
        exp_q.push_back(c);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic expect_word(input logic [31:0] w);
        int nib;
        exp_q.delete();
`ifdef UART_DUMP_HEX_EN
        for (int i = 7; i >= 0; i--) begin
            nib = int'((w >> (4 * i)) & 32'hF);
            if (nib < 10) exp_q.push_back(8'(48 + nib));        // '0'..'9'
            else          exp_q.push_back(8'(65 + nib - 10));   // 'A'..'F'
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
`endif
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Deliver one byte with rdy held for 'hold' cycles; the event is the
    // first clock edge after the drive.
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk); #1;
        rx_data     = b;
        rx_data_rdy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_data_rdy = 1'b0;
    endtask

    // Compare the captured response against the model, then clear.
    task automatic finish_resp(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        got_q.delete();
    endtask

    // Run until the expected number of bytes has been pushed, optionally
    // toggling fifo_full at random to create back-pressure.
    task automatic collect(input string tag, input bit rnd);
        int budget = 2000;
        while (got_q.size() < exp_q.size() && budget > 0) begin
            @(posedge clk); #1;
            fifo_full = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, 32'(got_q.size()), 32'(exp_q.size()));
        fifo_full = 1'b0;
        finish_resp(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},   32'(probe_sel),  32'd0);
        check({tag, "_step"},  32'(pipe_step),  32'd0);
        check({tag, "_din"},   32'(fifo_din),   32'd0);
        check({tag, "_wr"},    32'(fifo_wr_en), 32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_drop"},  32'(drop_cnt),   32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        logic [7:0] sel;
        int         pat [5];
        int         budget;

        for (int i = 0; i < 64; i++) probe_mem[i] = $urandom;
        probe_mem[5] = 32'hDEADBEEF;

        rst = 1'b1; rx_data = 8'h00; rx_data_rdy = 1'b0; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Step pulse: low, then high for exactly STEP_LEN cycles, then low.
        pat = '{0, 1, 1, 1, 0};
        expect_char(8'h4B);
        @(posedge clk); #1;
        rx_data = 8'h53; rx_data_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("step_pulse", 32'(pipe_step), 32'(pat[i]));
            if (i == 1) rx_data_rdy = 1'b0;
        end
        collect("step_resp", 1'b0);

        // Word read of probe 5 with 20 cycles of full after the 3rd byte.
        send_byte(8'h52, 1);
        send_byte(8'h05, 1);
        expect_word(32'hDEADBEEF);
        budget = 200;
        while (got_q.size() < 3 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("word_3rd_seen", 32'(got_q.size()), 32'd3);
        fifo_full = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("word_hold_no_push", 32'(got_q.size()), 32'd3);
        check("word_sel", 32'(probe_sel), 32'd5);
        collect("word_resp", 1'b0);

        // Unknown byte with rdy held 10 cycles: exactly one event.
        expect_char(8'h3F);
        send_byte(8'h41, 10);
        collect("held_rdy", 1'b0);

        // Byte arriving during SEND is dropped and does not disturb the reply.
        expect_char(8'h3F);
        fifo_full = 1'b1;
        send_byte(8'h41, 1);
        send_byte(8'h53, 1);
        exp_drop = sat_add(exp_drop, 1);
        #1 check("drop_one", 32'(drop_cnt), 32'(exp_drop));
        collect("drop_resp", 1'b0);

        // Randomized commands under random back-pressure.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            case ($urandom_range(0, 2))
                0: begin
                    expect_char(8'h4B);
                    send_byte(8'h53, $urandom_range(1, 4));
                    collect("rnd_step", 1'b1);
                end
                1: begin
                    sel = 8'($urandom);
                    expect_word(probe_mem[sel[5:0]]);
                    send_byte(8'h52, $urandom_range(1, 4));
                    send_byte(sel, $urandom_range(1, 4));
                    collect("rnd_word", 1'b1);
                    check("rnd_sel", 32'(probe_sel), 32'(sel[5:0]));
                end
                default: begin
                    do b = 8'($urandom); while (b == 8'h52 || b == 8'h53);
                    expect_char(8'h3F);
                    send_byte(b, $urandom_range(1, 4));
                    collect("rnd_unk", 1'b1);
                end
            endcase
        end

        // Saturation: 300 bytes while stuck in SEND behind a full FIFO.
        expect_char(8'h3F);
        fifo_full = 1'b1;
        send_byte(8'h3A, 1);
        for (int i = 0; i < 300; i++) send_byte(8'($urandom), 1);
        exp_drop = sat_add(exp_drop, 300);
        #1 check("drop_sat", 32'(drop_cnt), 32'(exp_drop));
        check("busy_while_full", 32'(busy), 32'd1);
        collect("sat_resp", 1'b0);

        // Reset in the middle of a step pulse, then a normal 'S'.
        send_byte(8'h53, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        got_q.delete();
        exp_drop = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_char(8'h4B);
        send_byte(8'h53, 1);
        collect("post_rst_step", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_debug_ctrl.md
Name: uart_debug_ctrl

Overview:
- Command/response engine between uart_rx and the tx char FIFO in the UART debug top.
- Consumes received bytes (rx_data / rx_data_rdy) and generates single-step pulses for the pipeline clock gate.
- Reads 32-bit pipeline probe words through an external selector mux and pushes formatted response bytes into the char FIFO (fifo_din / fifo_wr_en), honouring fifo_full.

Parameters:
- SEL_W, 6, width of probe selector (up to 64 probe words)
- STEP_LEN, 1, pipe_step pulse width in clk cycles (1..255)

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-high reset
- rx_data, input, 8, received byte from uart_rx; valid while rx_data_rdy high
- rx_data_rdy, input, 1, uart_rx ready; may stay high several cycles; rising edge = one byte
- probe_sel, output, SEL_W, selector to external probe mux
- probe_data, input, 32, mux output; combinational from probe_sel
- pipe_step, output, 1, step pulse to pipeline clock gate
- fifo_din, output, 8, byte to char FIFO
- fifo_wr_en, output, 1, one-cycle FIFO push strobe
- fifo_full, input, 1, char FIFO full
- busy, output, 1, high whenever state != IDLE
- drop_cnt, output, 8, bytes dropped while busy; saturates at 255

Behaviour:
- Reset (async, any state): state=IDLE; probe_sel=0; pipe_step=0; fifo_din=0; fifo_wr_en=0; busy=0; drop_cnt=0; rx edge-detect history reg=0.
- Byte event: registered rising edge of rx_data_rdy. rx_data is captured on that clk edge. One event per edge; a held-high rdy produces no further events.
- States: IDLE, GET_SEL, STEP, LATCH, SEND.
- IDLE:
  - 'S' (0x53) -> STEP.
  - 'R' (0x52) -> GET_SEL.
  - Any other byte -> SEND with response "?".
- GET_SEL:
  - Next byte event: probe_sel <= byte[SEL_W-1:0]; upper bits ignored; go to LATCH.
  - No timeout.
- LATCH:
  - Exactly one cycle. probe_data is sampled into a 32-bit shadow register on the edge leaving LATCH, one cycle after probe_sel updated.
  - Then SEND with the word response.
- STEP:
  - pipe_step high for STEP_LEN cycles, starting the cycle after the 'S' event.
  - Then SEND with response "K".
- SEND:
  - Emits the response bytes in order.
  - A byte is pushed (fifo_wr_en=1 for one cycle, fifo_din valid that same cycle) only in a cycle where fifo_full=0, sampled combinationally.
  - If fifo_full=1, no push and the byte index holds. No byte is lost or duplicated.
  - Maximum rate: one push per cycle.
  - After the last byte -> IDLE.
- Response formats:
  - "?" and "K" responses: single byte 0x3F or 0x4B, followed by CR 0x0D and LF 0x0A.
  - Word response format depends on UART_DUMP_HEX_EN (see Optional Feature).
- Byte events while state != IDLE and != GET_SEL: byte dropped, drop_cnt += 1 (saturating at 255).
- Byte event in the same cycle the state returns to IDLE: handled as a drop (state was not yet IDLE).
- Reset mid-SEND: the remaining bytes are abandoned; bytes already pushed stay in the FIFO.
- fifo_wr_en is never asserted when fifo_full=1.
- pipe_step is never asserted outside STEP.

Optional Feature:
- Macro: UART_DUMP_HEX_EN.
- Defined: word response is 8 uppercase ASCII hex digits, most significant nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0D 0x0A. Total 10 bytes.
- Undefined: word response is 4 raw bytes, most significant byte first, with no CR/LF. Total 4 bytes.
- "?" and "K" responses are identical in both builds.

Test Plan:
- Reset asserted mid-operation, then released -> all outputs 0, state IDLE; first 'S' accepted normally.
- Send 'S' with STEP_LEN=3 -> pipe_step high exactly 3 cycles starting one cycle after the event; FIFO receives 0x4B 0x0D 0x0A.
- Send 'R' then 0x05, with the mux returning 0xDEADBEEF for sel 5 -> probe_sel=5. HEX build: FIFO gets "DEADBEEF" 0x0D 0x0A. Raw build: FIFO gets DE AD BE EF.
- During a word SEND, hold fifo_full=1 for 20 cycles after the 3rd byte -> no fifo_wr_en while full; the sequence resumes at the 4th byte with no gaps or duplicates.
- Send 0x41 -> FIFO gets 0x3F 0x0D 0x0A. Send a byte while SEND is active -> drop_cnt=1, response unaffected. Hold rx_data_rdy high for 10 cycles -> exactly one event.
- Send 300 bytes while busy is forced (fifo_full held high) -> drop_cnt saturates at 255.
